// File: rtl/board_renderer.sv
// Sweeps the board RAM (or draws ranked result bands) and emits one pixel-plot
// command per board cell for the VGA adapter.
module board_renderer #(
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int RAM_LATENCY = 2,
  parameter int BAND_ROWS   = 30
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        done_ordering,
  input  logic [11:0] ordered_colours,
  input  logic [2:0]  ram_q,
  output logic [14:0] rd_address,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        frame_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PLOT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int WAIT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RAM_LATENCY - 1);
  localparam logic [7:0] X_LAST = 8'(X_MAX);
  localparam logic [6:0] Y_LAST = 7'(Y_MAX);

  logic [2:0]        state;
  logic              results_mode;
  logic [WAIT_W-1:0] wait_cnt;
  logic              last_pixel;
  logic [7:0]        x_adv;
  logic [6:0]        y_adv;

  function automatic logic [2:0] band_colour(input logic [6:0] row,
                                             input logic [11:0] ranks);
    if (row < 7'(BAND_ROWS))          return ranks[11:9];
    else if (row < 7'(2 * BAND_ROWS)) return ranks[8:6];
    else if (row < 7'(3 * BAND_ROWS)) return ranks[5:3];
    else                              return ranks[2:0];
  endfunction

  always_comb begin
    last_pixel = (x == X_LAST) && (y == Y_LAST);
    x_adv      = (x == X_LAST) ? 8'd0 : x + 8'd1;
    y_adv      = (x == X_LAST) ? y + 7'd1 : y;
  end

  // rd_address is reloaded together with the counters, so it already holds
  // the new pixel's address during FETCH and stays put through PLOT.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= S_IDLE;
      results_mode <= 1'b0;
      wait_cnt     <= '0;
      rd_address   <= '0;
      x            <= '0;
      y            <= '0;
      colour       <= '0;
      plot         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      plot       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            results_mode <= done_ordering;
            x            <= '0;
            y            <= '0;
            rd_address   <= '0;
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (results_mode) begin
            colour <= band_colour(y, ordered_colours);
            plot   <= 1'b1;
            state  <= S_PLOT;
          end else begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            colour <= ram_q;
            plot   <= 1'b1;
            state  <= S_PLOT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_PLOT: begin
          if (last_pixel) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            x          <= x_adv;
            y          <= y_adv;
            rd_address <= {x_adv, y_adv};
            state      <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/board_renderer.md
# board_renderer

Read-side counterpart to the game RAM writer. Sweeps the 160x120 board RAM through a dedicated read port and turns every stored 3-bit colour into a one-cycle pixel-plot command (x, y, colour, plot) for the VGA adapter. After `done_ordering` rises, it draws a results screen instead of reading RAM: four horizontal bands in ranking order taken from `ordered_colours`.

## Interface

Parameters:
- X_MAX, 159, last column index (x counter width 8)
- Y_MAX, 119, last row index (y counter width 7)
- RAM_LATENCY, 2, cycles from `rd_address` stable to `ram_q` valid (must be ≥1)
- BAND_ROWS, 30, rows per results band ((Y_MAX+1)/4)

Ports:
- CLOCK_50  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  level; frames run back-to-back while high
- done_ordering  in  1  selects results mode, sampled at frame start
- ordered_colours  in  12  ranked colours, [11:9] first place … [2:0] fourth place
- ram_q  in  3  RAM read data
- rd_address  out  15  RAM read address {x[7:0], y[6:0]}
- x  out  8  pixel column, valid when plot=1
- y  out  7  pixel row, valid when plot=1
- colour  out  3  pixel colour, valid when plot=1
- plot  out  1  one-cycle write strobe to the VGA adapter
- frame_done  out  1  one-cycle pulse after the last pixel of a frame

## Operation

- Reset values: rd_address=0, x=0, y=0, colour=000, plot=0, frame_done=0. State is IDLE and mode is BOARD.
- Sweep order is row-major: x runs 0..X_MAX inside, y runs 0..Y_MAX outside. x and y are the sweep counters.
- rd_address is {x,y} and is always registered.
- States:
  - IDLE: if enable is high, latch mode (RESULTS if done_ordering=1, else BOARD), clear x and y, go to FETCH. Otherwise stay in IDLE.
  - FETCH: rd_address={x,y}. BOARD mode goes to WAIT; RESULTS mode goes to PLOT.
  - WAIT: hold for RAM_LATENCY cycles. On the last WAIT cycle, colour<=ram_q. Then go to PLOT.
  - PLOT: plot=1 for exactly one cycle.
    - If x=X_MAX and y=Y_MAX, go to DONE.
    - Otherwise advance the counters and go to FETCH.
  - DONE: frame_done=1 for one cycle, then go to IDLE.
- BOARD colour is ram_q passed through unchanged, including 000 and unused codes.
- RESULTS colour, chosen in FETCH from y:
  - y<30: [11:9]
  - y<60: [8:6]
  - y<90: [5:3]
  - otherwise: [2:0]
- Counter advance: when x=X_MAX, x wraps to 0 and y increments; otherwise x increments. Neither counter ever exceeds its MAX.
- Mode is frozen for the whole frame. done_ordering and ordered_colours changes mid-frame do not take effect until the next IDLE→FETCH.
  - Exception: ordered_colours is read live in RESULTS mode. It is stable once done_ordering=1.
- Dropping enable mid-frame does not abort the frame. The frame completes and the block parks in IDLE.
- Reset mid-frame: outputs take their reset values on the next edge, the sweep is abandoned, and no frame_done is issued.
- Read-only: this block never writes RAM and has no wren.

## Timing

- BOARD pixel period: RAM_LATENCY+2 cycles (FETCH, RAM_LATENCY×WAIT, PLOT). That is 4 cycles at the default.
- RESULTS pixel period: 2 cycles (FETCH, PLOT).
- plot is high in exactly one cycle per pixel. x, y and colour are stable throughout that cycle.
- Frame length from the IDLE cycle that sees enable through the DONE cycle:
  - BOARD: 1 + 19200×(RAM_LATENCY+2) + 1 = 76802 cycles at the default.
  - RESULTS: 1 + 38400 + 1 = 38402 cycles.
- With enable held high, the next frame's first FETCH comes 2 cycles after the last PLOT (DONE, then IDLE).
- rd_address is constant from FETCH through PLOT of each pixel. No combinational path runs from ram_q to any output.

## Test plan

- Reset: pulse reset for 1 cycle at pixel (37,50) mid-BOARD frame → next cycle plot=0, frame_done=0, x=y=0, rd_address=0. No frame_done follows. With enable=1, the first new plot is at (0,0).
- BOARD sweep: RAM model with latency 2, preload {5,3}=001, {159,119}=110, all others 000, enable=1 → exactly 19200 plots.
  - Plot for (5,3) carries colour 001, exactly 3 cycles after rd_address=0x0283.
  - The last plot is (159,119) with colour 110.
  - frame_done pulses once, 76801 cycles after the IDLE start cycle.
- RESULTS: done_ordering=1, ordered_colours=010_001_110_100 → 19200 plots at a 2-cycle spacing.
  - Colours by row: y 0–29 →010, 30–59 →001, 60–89 →110, 90–119 →100.
  - No rd_address change after FETCH sets it.
- Mode freeze: raise done_ordering at pixel (80,60) of a BOARD frame → the rest of that frame stays BOARD (RAM colours, 4-cycle spacing). The following frame is RESULTS.
- enable drop: deassert enable at pixel (10,10) → the frame completes with all 19200 plots and one frame_done, then IDLE holds with plot=0 for 100+ cycles.
- Wrap: observe the transition (159,k)→(0,k+1) for k=0 and k=118. No plot ever has x>159 or y>119.
